// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RISC-V immediate decoder behind a two-entry skid buffer.
// One instruction per cycle in; immediate, one-hot format, illegal flag and tag out one cycle later.
module imm_gen_pipe #(
    parameter int XLEN       = 32,
    parameter int TAG_W      = 32,
    parameter bit SHAMT_ZEXT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [5:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    // Valid/ready: a beat moves on a side when that side's valid and ready are both high
    // at a rising clk edge; in_ready is a pure function of state and never looks at in_valid.

    localparam logic [5:0] FMT_R = 6'b000001;
    localparam logic [5:0] FMT_I = 6'b000010;
    localparam logic [5:0] FMT_S = 6'b000100;
    localparam logic [5:0] FMT_B = 6'b001000;
    localparam logic [5:0] FMT_U = 6'b010000;
    localparam logic [5:0] FMT_J = 6'b100000;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [5:0]       fmt;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t     dec;
    entry_t     main_q, main_d;
    entry_t     skid_q, skid_d;
    logic       main_valid_q, main_valid_d;
    logic       skid_valid_q, skid_valid_d;
    logic       in_fire;
    logic [2:0] funct3;

    assign funct3  = in_inst[14:12];
    assign in_fire = in_valid && in_ready;

    always_comb begin
        dec     = '0;
        dec.tag = in_tag;
        case (in_inst[6:0])
            7'b0110011: dec.fmt = FMT_R;
            7'b0010011: begin
                dec.fmt = FMT_I;
                if (SHAMT_ZEXT && (funct3 == 3'b001 || funct3 == 3'b101)) begin
                    if (XLEN == 64) dec.imm = XLEN'(in_inst[25:20]);
                    else            dec.imm = XLEN'(in_inst[24:20]);
                end else begin
                    dec.imm = XLEN'($signed(in_inst[31:20]));
                end
            end
            7'b0000011, 7'b1100111: begin
                dec.fmt = FMT_I;
                dec.imm = XLEN'($signed(in_inst[31:20]));
            end
            7'b0100011: begin
                dec.fmt = FMT_S;
                dec.imm = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
            end
            7'b1100011: begin
                dec.fmt = FMT_B;
                dec.imm = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                         in_inst[11:8], 1'b0}));
            end
            7'b0110111, 7'b0010111: begin
                dec.fmt = FMT_U;
                dec.imm = XLEN'($signed({in_inst[31:12], 12'h000}));
            end
            7'b1101111: begin
                dec.fmt = FMT_J;
                dec.imm = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                         in_inst[30:21], 1'b0}));
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    // Main drains whenever it is empty or consumed; skid only fills while main is stalled.
    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_d       = main_q;
        skid_d       = skid_q;
        if (!main_valid_q || out_ready) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                main_valid_d = 1'b1;
                main_d       = dec;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_d       = dec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
        end
    end

    assign in_ready    = !skid_valid_q;
    assign out_valid   = main_valid_q;
    assign out_imm     = main_q.imm;
    assign out_fmt     = main_q.fmt;
    assign out_illegal = main_q.illegal;
    assign out_tag     = main_q.tag;

endmodule
